// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - shared op kinds, field codes and FSM state for the instruction loader
package instr_encoder_loader_pkg;

    localparam logic [3:0] OPK_AND = 4'd0;
    localparam logic [3:0] OPK_SUB = 4'd1;
    localparam logic [3:0] OPK_ADD = 4'd2;
    localparam logic [3:0] OPK_ORR = 4'd3;
    localparam logic [3:0] OPK_CMP = 4'd4;
    localparam logic [3:0] OPK_MOV = 4'd5;
    localparam logic [3:0] OPK_LDR = 4'd6;
    localparam logic [3:0] OPK_STR = 4'd7;
    localparam logic [3:0] OPK_B   = 4'd8;
    localparam logic [3:0] OPK_BL  = 4'd9;
    localparam logic [3:0] OPK_BX  = 4'd10;

    // Data-processing cmd codes, as the controller decodes Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [23:0] BX_CONST = 24'h12FFF1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    function automatic logic [3:0] dp_cmd_of(input logic [3:0] kind);
        case (kind)
            OPK_SUB: dp_cmd_of = CMD_SUB;
            OPK_ADD: dp_cmd_of = CMD_ADD;
            OPK_ORR: dp_cmd_of = CMD_ORR;
            OPK_CMP: dp_cmd_of = CMD_CMP;
            OPK_MOV: dp_cmd_of = CMD_MOV;
            default: dp_cmd_of = CMD_AND;
        endcase
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// rtl/instr_word_pack.sv - combinational field-to-word encoder; flags op kinds with no encoding
module instr_word_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  op_kind,
    input  logic [3:0]  cond,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    input  logic [3:0]  rm,
    input  logic        imm_sel,
    input  logic [23:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic [11:0] src2;
    logic [3:0]  rd_f;
    logic [3:0]  rn_f;
    logic        s_bit;

    // CMP only sets flags, so S is forced and Rd is zeroed; MOV has no first source
    always_comb begin
        src2  = imm_sel ? imm[11:0] : {imm[11:4], rm};
        s_bit = (op_kind == OPK_CMP);
        rd_f  = (op_kind == OPK_CMP) ? 4'b0000 : rd;
        rn_f  = (op_kind == OPK_MOV) ? 4'b0000 : rn;
    end

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op_kind)
            OPK_AND, OPK_SUB, OPK_ADD, OPK_ORR, OPK_CMP, OPK_MOV:
                word = {cond, OP_DP, imm_sel, dp_cmd_of(op_kind), s_bit, rn_f, rd_f, src2};
            OPK_LDR:
                word = {cond, OP_MEM, 5'b01100, 1'b1, rn, rd, imm[11:0]};
            OPK_STR:
                word = {cond, OP_MEM, 5'b01100, 1'b0, rn, rd, imm[11:0]};
            OPK_B:
                word = {cond, OP_BR, 2'b10, imm};
            OPK_BL:
                word = {cond, OP_BR, 2'b11, imm};
            OPK_BX:
                word = {cond, BX_CONST, rm};
            default:
                legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - accepts symbolic instructions and writes encoded words to sequential memory addresses
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_kind,
    input  logic [3:0]        cond,
    input  logic [3:0]        rd,
    input  logic [3:0]        rn,
    input  logic [3:0]        rm,
    input  logic              imm_sel,
    input  logic [23:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic [31:0] wdata_q;

    instr_word_pack u_pack (
        .op_kind (op_kind),
        .cond    (cond),
        .rd      (rd),
        .rn      (rn),
        .rm      (rm),
        .imm_sel (imm_sel),
        .imm     (imm),
        .word    (word),
        .legal   (legal)
    );

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal requests complete the handshake but never enter WRITE
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept && legal) state_d = WRITE;
                WRITE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == IDLE) & ~full & ~clr;
        mem_we   = (state_q == WRITE) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_q <= '0;
            count   <= '0;
            full    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (accept && legal) begin
                wdata_q <= word;
            end
            if (clr) begin
                count <= '0;
                full  <= 1'b0;
                err   <= 1'b0;
            end else begin
                if (mem_we) begin
                    count <= count + 1'b1;
                    full  <= ((count + 1'b1) == DEPTH_C);
                end
                if (accept && !legal) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign mem_addr  = count[ADDR_W-1:0];
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_kind;
    logic [3:0]        cond;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [3:0]        rm;
    logic              imm_sel;
    logic [23:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int errors = 0;
    int checks = 0;

    instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_kind   (op_kind),
        .cond      (cond),
        .rd        (rd),
        .rn        (rn),
        .rm        (rm),
        .imm_sel   (imm_sel),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] k, input logic [3:0] c, input logic [3:0] d,
                           input logic [3:0] n, input logic [3:0] m, input logic s,
                           input logic [23:0] i);
        op_kind = k; cond = c; rd = d; rn = n; rm = m; imm_sel = s; imm = i;
    endtask

    // One accepted request; returns at the start of the following (WRITE) cycle
    task automatic drive(input logic [3:0] k, input logic [3:0] c, input logic [3:0] d,
                         input logic [3:0] n, input logic [3:0] m, input logic s,
                         input logic [23:0] i);
        set_req(k, c, d, n, m, s, i);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h want 0", mem_we); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: got full=%0b err=%0b want 0 0", full, err); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_dp;
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL add_we: got %0b want 1", mem_we); end
        checks++; if (mem_addr !== 2'd0) begin errors++; $display("FAIL add_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'hE0821003) begin errors++; $display("FAIL add_wdata: got %h want E0821003", mem_wdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_ready_in_write: got %0b want 0", in_ready); end
        step();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL add_count: got %0d want 1", count); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL add_we_single: got %0b want 0", mem_we); end
        // MOV R2,#0xFF with rn=9 supplied; rn must be forced to zero
        drive(4'd5, 4'hE, 4'd2, 4'd9, 4'd0, 1'b1, 24'h0000FF);
        checks++; if (mem_addr !== 2'd1 || mem_wdata !== 32'hE3A020FF) begin errors++; $display("FAIL mov_word: got addr=%0d data=%h want addr=1 data=E3A020FF", mem_addr, mem_wdata); end
        step();
        do_clr();
    endtask

    task automatic test_cmp_mem;
        // rd=7 supplied to CMP; rd must be forced to zero and S set
        drive(4'd4, 4'hE, 4'd7, 4'd4, 4'd0, 1'b1, 24'h000005);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'hE3540005) begin errors++; $display("FAIL cmp_word: got we=%0b addr=%0d data=%h want 1 0 E3540005", mem_we, mem_addr, mem_wdata); end
        step();
        drive(4'd6, 4'hE, 4'd0, 4'd1, 4'd0, 1'b1, 24'h000008);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'hE5910008) begin errors++; $display("FAIL ldr_word: got we=%0b addr=%0d data=%h want 1 1 E5910008", mem_we, mem_addr, mem_wdata); end
        step();
        drive(4'd7, 4'hE, 4'd0, 4'd1, 4'd0, 1'b0, 24'h000008);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd2 || mem_wdata !== 32'hE5810008) begin errors++; $display("FAIL str_word: got we=%0b addr=%0d data=%h want 1 2 E5810008", mem_we, mem_addr, mem_wdata); end
        step();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mem_count: got %0d want 3", count); end
        do_clr();
    endtask

    task automatic test_branch;
        drive(4'd9, 4'hE, 4'd0, 4'd0, 4'd0, 1'b0, 24'h000010);
        checks++; if (mem_addr !== 2'd0 || mem_wdata !== 32'hEB000010) begin errors++; $display("FAIL bl_word: got addr=%0d data=%h want 0 EB000010", mem_addr, mem_wdata); end
        step();
        drive(4'd8, 4'h1, 4'd0, 4'd0, 4'd0, 1'b0, 24'h000010);
        checks++; if (mem_addr !== 2'd1 || mem_wdata !== 32'h1A000010) begin errors++; $display("FAIL b_word: got addr=%0d data=%h want 1 1A000010", mem_addr, mem_wdata); end
        step();
        drive(4'd10, 4'hE, 4'd0, 4'd0, 4'd14, 1'b0, 24'h0);
        checks++; if (mem_addr !== 2'd2 || mem_wdata !== 32'hE12FFF1E) begin errors++; $display("FAIL bx_word: got addr=%0d data=%h want 2 E12FFF1E", mem_addr, mem_wdata); end
        step();
        do_clr();
    endtask

    task automatic test_full;
        int writes;
        int exp_addr;
        writes   = 0;
        exp_addr = 0;
        set_req(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (mem_we === 1'b1) begin
                checks++; if (mem_addr !== exp_addr[ADDR_W-1:0] || exp_addr >= DEPTH) begin errors++; $display("FAIL full_addr: got %0d want %0d (write #%0d)", mem_addr, exp_addr, writes); end
                writes++;
                exp_addr++;
            end
        end
        checks++; if (writes !== DEPTH) begin errors++; $display("FAIL full_writes: got %0d want %0d", writes, DEPTH); end
        checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL full_flags: got full=%0b ready=%0b count=%0d want 1 0 4", full, in_ready, count); end
        in_valid = 1'b0;
        do_clr();
        checks++; if (count !== 3'd0 || full !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_clr: got count=%0d full=%0b ready=%0b want 0 0 1", count, full, in_ready); end
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0) begin errors++; $display("FAIL full_rewrite: got we=%0b addr=%0d want 1 0", mem_we, mem_addr); end
        step();
        do_clr();
    endtask

    task automatic test_illegal;
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        step();
        drive(4'd12, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err: got %0b want 1", err); end
        checks++; if (mem_we !== 1'b0 || count !== 3'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL ill_nowrite: got we=%0b count=%0d ready=%0b want 0 1 1", mem_we, count, in_ready); end
        drive(4'd0, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'hE0021003) begin errors++; $display("FAIL ill_next: got we=%0b addr=%0d data=%h want 1 1 E0021003", mem_we, mem_addr, mem_wdata); end
        step();
        checks++; if (count !== 3'd2 || err !== 1'b1) begin errors++; $display("FAIL ill_sticky: got count=%0d err=%0b want 2 1", count, err); end
        do_clr();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_clr: got err=%0b want 0", err); end
    endtask

    task automatic test_clr_write;
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        step();
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        clr = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL clrw_we: got %0b want 0", mem_we); end
        step();
        clr = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || full !== 1'b0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL clrw_after: got count=%0d full=%0b ready=%0b we=%0b want 0 0 1 0", count, full, in_ready, mem_we); end
    endtask

    task automatic test_rst_write;
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        step();
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rstw_now: got we=%0b count=%0d want 0 0", mem_we, count); end
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rstw_after: got ready=%0b we=%0b count=%0d want 1 0 0", in_ready, mem_we, count); end
        drive(4'd2, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 24'h0);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0) begin errors++; $display("FAIL rstw_next: got we=%0b addr=%0d want 1 0", mem_we, mem_addr); end
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        set_req(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 24'h0);
        test_reset();
        test_dp();
        test_cmp_mem();
        test_branch();
        test_full();
        test_illegal();
        test_clr_write();
        test_rst_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Program loader that sits in front of instruction memory. It is the writer-side counterpart of the controller's instruction decoder. It accepts symbolic instruction requests through a valid/ready handshake and encodes each one into a 32-bit word, using the same field layout the controller decodes: Cond=[31:28], Op=[27:26], Funct=[25:20]. It then writes the words to sequential instruction-memory addresses. It is used by testbenches and boot logic to fill program memory for the single-cycle core.

Parameters:
DEPTH, 64, number of instruction words the target memory holds.
ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  synchronous clear of address counter, full and err.
in_valid  in  1  request valid.
in_ready  out  1  loader can accept a request this cycle.
op_kind  in  4  0 AND, 1 SUB, 2 ADD, 3 ORR, 4 CMP, 5 MOV, 6 LDR, 7 STR, 8 B, 9 BL, 10 BX; 11-15 illegal.
cond  in  4  condition field (0000 EQ, 0001 NE, 1110 AL).
rd  in  4  destination register.
rn  in  4  first source / base register.
rm  in  4  second source register; also the BX target.
imm_sel  in  1  data-processing only: 1 selects the immediate operand (I bit).
imm  in  24  immediate: [11:0] for DP and memory ops, [23:0] for branches, [11:4] for the shift field in DP register form.
mem_we  out  1  instruction-memory write strobe.
mem_addr  out  ADDR_W  word address.
mem_wdata  out  32  encoded instruction.
count  out  ADDR_W+1  number of words written since reset/clr.
full  out  1  count == DEPTH.
err  out  1  sticky: an illegal op_kind was accepted.

Behaviour:
- Reset (rst_n low, async): state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0.
- in_ready = (state==IDLE) & !full & !clr, combinational.
- Accept occurs when in_valid & in_ready at edge T. Fields are registered and the state goes to WRITE.
- Cycle after T (WRITE): mem_we=1 for exactly one cycle, mem_addr=count[ADDR_W-1:0], mem_wdata=encoded word. At the end of that cycle count increments, full updates, and the state returns to IDLE.
- Latency is 1 cycle from accept to write. Throughput is one instruction per 2 cycles. in_ready is 0 during WRITE.
- Encoding (S=0 unless stated):
  - DP: {cond, 2'b00, imm_sel, cmd, S, rn, rd, src2}, with cmd AND=0000, SUB=0010, ADD=0100, CMP=1010, ORR=1100, MOV=1101.
  - src2 = imm[11:0] if imm_sel=1, else {imm[11:4], rm}.
  - CMP forces S=1 and rd=0000. MOV forces rn=0000.
  - LDR/STR: {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, L, rn, rd, imm[11:0]}, with L=1 for LDR and 0 for STR. imm_sel is ignored.
  - B: {cond, 4'b1010, imm[23:0]}. BL: {cond, 4'b1011, imm[23:0]}.
  - BX: {cond, 24'h12FFF1, rm}.
- Illegal op_kind: the request is accepted (handshake completes) and err is set sticky. There is no WRITE cycle; the state stays in IDLE, and count and mem_addr are unchanged.
- Full: when count==DEPTH, in_ready=0 and requests are held off with no wrap-around. Only clr or reset re-enables writing.
- clr has priority over everything. If asserted during WRITE, mem_we is forced low that cycle, the word is dropped, and count=0, full=0, err=0, state=IDLE.
- Reset asserted mid-WRITE: mem_we drops immediately (async) and the word is lost.
- Unused upper bits of count beyond DEPTH never occur.

Decomposition:
- Shared package: op_kind constants, DP cmd codes (matching the controller's Funct[4:1] decode), Op codes 00/01/10, the BX constant 24'h12FFF1, and state enum {IDLE, WRITE}.
- One natural sub-module: instr_word_pack, a purely combinational field-to-word encoder. The top holds the FSM, registers, counter and flags.

Test Plan:
- ADD AL R1,R2,R3 (op_kind=2, cond=E, rd=1, rn=2, rm=3, imm_sel=0, imm=0) -> one cycle later mem_we=1, addr=0, wdata=0xE0821003; count=1.
- CMP R4,#5 (op_kind=4, imm_sel=1, imm=0x005, rn=4) -> wdata=0xE3540005. Then LDR R0,[R1,#8] -> 0xE5910008 at addr 1, and STR same fields -> 0xE5810008 at addr 2.
- BL imm=0x000010 cond=E -> 0xEB000010. B cond=1 (NE) imm=0x000010 -> 0x1A000010. BX rm=14 cond=E -> 0xE12FFF1E.
- DEPTH=4, in_valid held high with legal requests -> exactly 4 writes at addr 0..3, full=1, in_ready=0, no 5th mem_we. Then clr pulse -> count=0, full=0, next write lands at addr 0.
- op_kind=12 -> err=1, no mem_we, count unchanged. A following legal request writes at the same address it would have used without the illegal request.
- clr asserted during WRITE cycle, and separately rst_n pulsed low mid-WRITE -> mem_we=0 that cycle, count=0, state IDLE, in_ready high once clr/reset is released.
